instr_encoder: RTL and testbench

Sequential MIPS instruction encoder and program loader: the encoding counterpart of the control decoder. Accepts symbolic instruction descriptors over a valid/ready handshake, packs them into 32-bit R/I-type words using the opcode/funct assignments the control decoder interprets, and writes them sequentially into instruction memory. Terminates a program with a self-branch halt word. Sits between the test/boot sequencer and the instruction memory write port.

---
 rtl/instr_encoder.sv | 123 ++++++++++++
 tb/tb_instr_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS descriptors into R/I-type words and loads them
// sequentially into instruction memory, sealing the program with a self-branch halt.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              seal,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEAL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0] HALT = 32'h1000_FFFF;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       enc;
    logic              legal;
    logic              hs;

    assign full       = count_q == DEPTH;
    assign in_ready   = state_q == LOAD && !full;
    assign done       = state_q == DONE;
    assign count      = count_q;
    assign err        = err_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign hs         = in_valid && in_ready;

    always_comb begin
        legal = 1'b1;
        enc   = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b000000};
        case (in_kind)
            4'd0:    enc[5:0] = 6'b100000;
            4'd1:    enc[5:0] = 6'b100010;
            4'd2:    enc[5:0] = 6'b100100;
            4'd3:    enc[5:0] = 6'b100101;
            4'd4:    enc[5:0] = 6'b101010;
            4'd5:    enc[5:0] = 6'b100111;
            4'd6:    enc[5:0] = 6'b011000;
            4'd7:    enc[5:0] = 6'b011010;
            4'd8:    enc = {6'b001000, in_rs, in_rt, in_imm};
            4'd9:    enc = {6'b100011, in_rs, in_rt, in_imm};
            4'd10:   enc = {6'b101011, in_rs, in_rt, in_imm};
            4'd11:   enc = {6'b000100, in_rs, in_rt, in_imm};
            default: legal = 1'b0;
        endcase
    end

    // start outranks everything; a write already on the outputs still finishes this cycle
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = LOAD;
            count_d = '0;
            err_d   = 1'b0;
        end else if (state_q == LOAD) begin
            if (hs && legal) begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = enc;
                count_d = count_q + 1'b1;
            end
            if (hs && !legal) err_d = 1'b1;
            if (seal) state_d = SEAL;
        end else if (state_q == SEAL) begin
            state_d = DONE;
            if (full) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = HALT;
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed bench with write scoreboards for a 64-word and a 4-word encoder.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, seal = 1'b0, in_valid = 1'b0;
    logic        start2 = 1'b0, seal2 = 1'b0, in_valid2 = 1'b0;
    logic [3:0]  in_kind = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic        in_ready, imem_we, full, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;
    logic        in_ready2, imem_we2, full2, done2, err2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  count2;
    logic [39:0] q[$];
    logic [39:0] q2[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seal(seal), .in_valid(in_valid),
        .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .done(done), .err(err)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .seal(seal2), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .count(count2), .full(full2), .done(done2), .err(err2)
    );

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic desc(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm);
        in_kind = k;
        in_rs = rs;
        in_rt = rt;
        in_rd = rd;
        in_imm = imm;
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            if (q.size() == 0) chk("unexpected_write", {2'b0, imem_addr, imem_wdata}, 40'hFF_FFFF_FFFF);
            else chk("write", {2'b0, imem_addr, imem_wdata}, q.pop_front());
        end
        if (imem_we2) begin
            if (q2.size() == 0) chk("unexpected_write2", {6'b0, imem_addr2, imem_wdata2}, 40'hFF_FFFF_FFFF);
            else chk("write2", {6'b0, imem_addr2, imem_wdata2}, q2.pop_front());
        end
    end

    initial begin
        #12;
        chk("rst_outputs", {33'b0, in_ready, imem_we, done, err, full, count == 0, imem_wdata == 0},
            {33'b0, 7'b0000011});
        rst_n = 1'b1;
        step();
        step();
        chk("idle_ready", in_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_ready", in_ready, 1);
        desc(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        in_valid = 1'b1;
        q.push_back({8'd0, 32'h0022_1820});
        step();
        in_valid = 1'b0;
        chk("count_after_add", count, 1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        desc(4'd9, 5'd16, 5'd8, 5'd0, 16'h0004);
        q.push_back({8'd0, 32'h8E08_0004});
        step();
        desc(4'd8, 5'd0, 5'd2, 5'd0, 16'hFFFF);
        q.push_back({8'd1, 32'h2002_FFFF});
        step();
        desc(4'd6, 5'd5, 5'd6, 5'd4, 16'd0);
        q.push_back({8'd2, 32'h00A6_2018});
        step();
        in_valid = 1'b0;
        #5;
        chk("b2b_drained", q.size(), 0);
        chk("b2b_count", count, 3);
        step();
        desc(4'd13, 5'd1, 5'd1, 5'd1, 16'd1);
        in_valid = 1'b1;
        chk("illegal_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("illegal_err", err, 1);
        chk("illegal_count", count, 3);
        desc(4'd3, 5'd7, 5'd8, 5'd9, 16'd0);
        in_valid = 1'b1;
        q.push_back({8'd3, 32'h00E8_4825});
        step();
        in_valid = 1'b0;
        chk("err_sticky", err, 1);
        desc(4'd10, 5'd29, 5'd31, 5'd0, 16'h0008);
        in_valid = 1'b1;
        seal = 1'b1;
        q.push_back({8'd4, 32'hAFBF_0008});
        q.push_back({8'd5, 32'h1000_FFFF});
        step();
        in_valid = 1'b0;
        seal = 1'b0;
        chk("seal_state", {in_ready, done}, 2'b00);
        step();
        chk("done_state", {in_ready, done}, 2'b01);
        chk("done_count", count, 6);
        #5;
        chk("seal_drained", q.size(), 0);
        step();
        in_valid = 1'b1;
        seal = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        seal = 1'b0;
        in_valid = 1'b0;
        chk("restart", {count, err, done, in_ready}, {7'd0, 3'b001});
        in_valid2 = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        desc(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        q2.push_back({8'd0, 32'h0022_1820});
        step();
        desc(4'd1, 5'd1, 5'd2, 5'd3, 16'd0);
        q2.push_back({8'd1, 32'h0022_1822});
        step();
        desc(4'd2, 5'd1, 5'd2, 5'd3, 16'd0);
        q2.push_back({8'd2, 32'h0022_1824});
        step();
        desc(4'd4, 5'd1, 5'd2, 5'd3, 16'd0);
        q2.push_back({8'd3, 32'h0022_182A});
        step();
        desc(4'd0, 5'd4, 5'd4, 5'd4, 16'd0);
        step();
        chk("full_flag", {full2, in_ready2}, 2'b10);
        step();
        chk("full_stall_count", count2, 4);
        seal2 = 1'b1;
        step();
        seal2 = 1'b0;
        in_valid2 = 1'b0;
        step();
        chk("full_seal", {done2, err2, count2}, {2'b11, 3'd4});
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("full_restart", {count2, err2, in_ready2}, {3'd0, 2'b01});
        desc(4'd7, 5'd5, 5'd6, 5'd0, 16'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pre_reset_we", {imem_we, imem_wdata}, {1'b1, 32'h00A6_001A});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {imem_we, count, in_ready, done}, {1'b0, 7'd0, 2'b00});
        step();
        rst_n = 1'b1;
        step();
        chk("reset_needs_start", in_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ready_after_start", in_ready, 1);
        step();
        chk("final_q", q.size(), 0);
        chk("final_q2", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
